// File: rtl/conv1d_pkg.sv
// Shared types and arithmetic helpers for the streaming 1-D convolution.
package conv1d_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  // Common width that carries any accumulator into the saturation helper.
  localparam int SAT_W = 64;

  function automatic int acc_width(input int t, input int m);
    return 2 * t + $clog2(m);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_t(input logic signed [SAT_W-1:0] acc,
                                                    input int t);
    logic signed [SAT_W-1:0] hi, lo;
    hi = (64'sd1 <<< (t - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (t - 1));
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/conv1d_mac.sv
// One MAC lane: registered product, then accumulator that clears at group start.
module conv1d_mac #(
  parameter int T     = 16,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [T-1:0]     a,
  input  logic signed [T-1:0]     b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*T-1:0]   prod_q;
  logic                    vld_q;
  logic signed [ACC_W-1:0] acc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      if (en) prod_q <= a * b;
      vld_q <= en;
      // clear wins: the first product of a group lands one cycle after it
      if (clear)      acc_q <= '0;
      else if (vld_q) acc_q <= acc_q + ACC_W'(prod_q);
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv1d_stream.sv
// Streaming valid-mode 1-D convolution, P lanes serialised onto one output.
// Optional CONV1D_RELU_EN clamps negative saturated results to zero.
module conv1d_stream import conv1d_pkg::*; #(
  parameter int N = 64,
  parameter int M = 8,
  parameter int T = 16,
  parameter int P = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic signed [T-1:0] s_data_in_x,
  input  logic                s_valid_x,
  output logic                s_ready_x,
  input  logic signed [T-1:0] s_data_in_f,
  input  logic                s_valid_f,
  output logic                s_ready_f,
  output logic signed [T-1:0] m_data_out_y,
  output logic                m_valid_y,
  input  logic                m_ready_y
);

  localparam int G     = (N - M + 1) / P;
  localparam int ACC_W = acc_width(T, M);
  localparam int XW    = $clog2(N + 1);
  localparam int FW    = $clog2(M + 1);
  localparam int XIW   = (N > 1) ? $clog2(N) : 1;
  localparam int FIW   = (M > 1) ? $clog2(M) : 1;
  localparam int CW    = $clog2(M + 2);
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int OW    = (P > 1) ? $clog2(P) : 1;

  if ((N - M + 1) % P != 0) begin : g_bad_p
    $error("conv1d_stream: P must divide N-M+1");
  end
  if (N < M) begin : g_bad_n
    $error("conv1d_stream: N must be >= M");
  end
  if (ACC_W > SAT_W) begin : g_bad_w
    $error("conv1d_stream: accumulator wider than saturation helper");
  end

  state_t          state_q, state_d;
  logic [XW-1:0]   xcnt_q, xcnt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [CW-1:0]   ccnt_q, ccnt_d;
  logic [GW-1:0]   g_q, g_d;
  logic [OW-1:0]   ocnt_q, ocnt_d;
  logic            rdy_x_q, rdy_f_q;

  logic [T-1:0]    xmem [N];
  logic [T-1:0]    fmem [M];
  logic [P-1:0][T-1:0]     outbuf;
  logic [P-1:0][T-1:0]     lane_y;
  logic [P-1:0][ACC_W-1:0] lane_acc;

  logic            x_fire, f_fire, y_fire;
  logic            mac_clr, mac_en, latch;
  logic [FIW-1:0]  tap;

  assign x_fire  = rdy_x_q && s_valid_x;
  assign f_fire  = rdy_f_q && s_valid_f;
  assign y_fire  = (state_q == DRAIN) && m_ready_y;
  assign mac_clr = (state_q == COMPUTE) && (ccnt_q == '0);
  assign mac_en  = (state_q == COMPUTE) && (ccnt_q < CW'(M));
  assign latch   = (state_q == COMPUTE) && (ccnt_q == CW'(M + 1));
  // Tail cycles of COMPUTE park on tap 0 so lane addresses stay in range.
  assign tap     = (ccnt_q < CW'(M)) ? FIW'(ccnt_q) : '0;

  always_comb begin
    state_d = state_q;
    xcnt_d  = xcnt_q;
    fcnt_d  = fcnt_q;
    ccnt_d  = ccnt_q;
    g_d     = g_q;
    ocnt_d  = ocnt_q;
    unique case (state_q)
      LOAD: begin
        if (x_fire) xcnt_d = xcnt_q + 1'b1;
        if (f_fire) fcnt_d = fcnt_q + 1'b1;
        if (xcnt_q == XW'(N) && fcnt_q == FW'(M)) begin
          state_d = COMPUTE;
          g_d     = '0;
          ccnt_d  = '0;
        end
      end
      COMPUTE: begin
        if (latch) begin
          state_d = DRAIN;
          ocnt_d  = '0;
        end else begin
          ccnt_d  = ccnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (y_fire) begin
          if (ocnt_q == OW'(P - 1)) begin
            ocnt_d = '0;
            if (g_q == GW'(G - 1)) begin
              state_d = LOAD;
              xcnt_d  = '0;
              fcnt_d  = '0;
              g_d     = '0;
            end else begin
              state_d = COMPUTE;
              g_d     = g_q + 1'b1;
              ccnt_d  = '0;
            end
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      xcnt_q  <= '0;
      fcnt_q  <= '0;
      ccnt_q  <= '0;
      g_q     <= '0;
      ocnt_q  <= '0;
      rdy_x_q <= 1'b0;
      rdy_f_q <= 1'b0;
      outbuf  <= '0;
    end else begin
      state_q <= state_d;
      xcnt_q  <= xcnt_d;
      fcnt_q  <= fcnt_d;
      ccnt_q  <= ccnt_d;
      g_q     <= g_d;
      ocnt_q  <= ocnt_d;
      // Ready is registered from next-state so it never follows valid.
      rdy_x_q <= (state_d == LOAD) && (xcnt_d != XW'(N));
      rdy_f_q <= (state_d == LOAD) && (fcnt_d != FW'(M));
      if (latch) outbuf <= lane_y;
    end
  end

  always_ff @(posedge clk) begin
    if (x_fire) xmem[xcnt_q[XIW-1:0]] <= s_data_in_x;
    if (f_fire) fmem[fcnt_q[FIW-1:0]] <= s_data_in_f;
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    logic [XIW-1:0]      xi;
    logic signed [T-1:0] y_sat;
    assign xi = XIW'(int'(g_q) * P + p + int'(tap));
    conv1d_mac #(.T(T), .ACC_W(ACC_W)) u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (mac_clr),
      .en      (mac_en),
      .a       (xmem[xi]),
      .b       (fmem[tap]),
      .acc     (lane_acc[p])
    );
    assign y_sat = T'(sat_t(SAT_W'(signed'(lane_acc[p])), T));
`ifdef CONV1D_RELU_EN
    assign lane_y[p] = lane_acc[p][ACC_W-1] ? '0 : y_sat;
`else
    assign lane_y[p] = y_sat;
`endif
  end

  if (P == 1) begin : g_out1
    assign m_data_out_y = outbuf[0];
  end else begin : g_outp
    assign m_data_out_y = outbuf[ocnt_q];
  end

  assign m_valid_y = (state_q == DRAIN);
  assign s_ready_x = rdy_x_q;
  assign s_ready_f = rdy_f_q;

endmodule

// File: tb/tb_conv1d_stream.sv
// Directed and randomized bench for conv1d_stream with a plain-arithmetic model.
module tb_conv1d_stream;
  localparam int N = 8, M = 3, T = 16, P = 2, NY = N - M + 1;

  logic                clk = 1'b0;
  logic                reset_n;
  logic signed [T-1:0] s_data_in_x, s_data_in_f, m_data_out_y;
  logic                s_valid_x, s_ready_x, s_valid_f, s_ready_f;
  logic                m_valid_y, m_ready_y;

  int tests = 0, fails = 0;
  bit rnd_v = 0, rnd_r = 0;
  logic signed [T-1:0] xv [N];
  logic signed [T-1:0] fv [M];
  logic signed [T-1:0] ev [NY];

  always #5 clk = ~clk;

  conv1d_stream #(.N(N), .M(M), .T(T), .P(P)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_data_in_x  (s_data_in_x),
    .s_valid_x    (s_valid_x),
    .s_ready_x    (s_ready_x),
    .s_data_in_f  (s_data_in_f),
    .s_valid_f    (s_valid_f),
    .s_ready_f    (s_ready_f),
    .m_data_out_y (m_data_out_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [T-1:0] ref_y(input int k);
    longint s, hi, lo;
    s  = 0;
    hi = (longint'(1) << (T - 1)) - 1;
    lo = -(longint'(1) << (T - 1));
    for (int m = 0; m < M; m++) s += longint'(xv[k + m]) * longint'(fv[m]);
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
`ifdef CONV1D_RELU_EN
    if (s < 0) s = 0;
`endif
    return T'(s);
  endfunction

  task automatic set_basic();
    for (int i = 0; i < N; i++) xv[i] = T'(i + 1);
    for (int m = 0; m < M; m++) fv[m] = 16'sd1;
    ev = '{16'sd6, 16'sd9, 16'sd12, 16'sd15, 16'sd18, 16'sd21};
  endtask

  task automatic send_x();
    int i = 0, cyc = 0;
    while (i < N && cyc < 1000) begin
      @(negedge clk); cyc++;
      s_valid_x   = rnd_v ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_in_x = xv[i];
      if (s_valid_x && s_ready_x) i++;
    end
    @(negedge clk);
    s_valid_x = 1'b0;
    check("x_sent", i, N);
  endtask

  task automatic send_f();
    int i = 0, cyc = 0;
    while (i < M && cyc < 1000) begin
      @(negedge clk); cyc++;
      s_valid_f   = rnd_v ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_in_f = fv[i];
      if (s_valid_f && s_ready_f) i++;
    end
    @(negedge clk);
    s_valid_f = 1'b0;
    check("f_sent", i, M);
  endtask

  task automatic recv_y();
    int j = 0, cyc = 0;
    bit held = 0;
    logic signed [T-1:0] hd = '0;
    while (j < NY && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (held) begin
        check("stall_valid", m_valid_y, 1);
        check("stall_data", m_data_out_y, hd);
      end
      m_ready_y = rnd_r ? 1'($urandom_range(0, 1)) : 1'b1;
      held = 0;
      if (m_valid_y) begin
        if (j == 0) begin
          check("no_rdy_x_drain", s_ready_x, 0);
          check("no_rdy_f_drain", s_ready_f, 0);
        end
        if (m_ready_y) begin
          check($sformatf("y%0d", j), m_data_out_y, ev[j]);
          j++;
        end else begin
          held = 1;
          hd   = m_data_out_y;
        end
      end
    end
    check("y_count", j, NY);
    @(negedge clk);
    m_ready_y = 1'b0;
    check("valid_fall", m_valid_y, 0);
  endtask

  task automatic do_run(input int mode);
    if (mode == 1) begin
      send_f();
      send_x();
    end else begin
      fork
        send_x();
        send_f();
      join
    end
    recv_y();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, m_valid_y, 0);
    check({tag, "_data"}, m_data_out_y, 0);
    check({tag, "_rdy_x"}, s_ready_x, 0);
    check({tag, "_rdy_f"}, s_ready_f, 0);
  endtask

  initial begin
    int cyc;
    s_valid_x = 0; s_valid_f = 0; m_ready_y = 0;
    s_data_in_x = '0; s_data_in_f = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // basic run, then f ahead of x, then random interleave
    set_basic(); do_run(0);
    set_basic(); do_run(1);
    rnd_v = 1; set_basic(); do_run(0); rnd_v = 0;

    // saturation corners
    for (int i = 0; i < N; i++) xv[i] = 16'sh7FFF;
    for (int m = 0; m < M; m++) fv[m] = 16'sh7FFF;
    for (int k = 0; k < NY; k++) ev[k] = 16'sh7FFF;
    do_run(0);
    for (int i = 0; i < N; i++) xv[i] = 16'sh8000;
`ifdef CONV1D_RELU_EN
    for (int k = 0; k < NY; k++) ev[k] = 16'sh0000;
`else
    for (int k = 0; k < NY; k++) ev[k] = 16'sh8000;
`endif
    do_run(0);

    // randomized runs against the reference model
    rnd_v = 1; rnd_r = 1;
    for (int r = 0; r < 156; r++) begin
      for (int i = 0; i < N; i++)
        xv[i] = r[0] ? T'($urandom) : T'(int'($urandom_range(0, 511)) - 256);
      for (int m = 0; m < M; m++)
        fv[m] = r[0] ? T'($urandom) : T'(int'($urandom_range(0, 511)) - 256);
      for (int k = 0; k < NY; k++) ev[k] = ref_y(k);
      do_run(int'($urandom_range(0, 1)));
    end
    rnd_v = 0; rnd_r = 0;

    // reset in the middle of COMPUTE
    set_basic();
    fork send_x(); send_f(); join
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_compute");
    @(negedge clk);
    reset_n = 1'b1;
    set_basic(); do_run(0);

    // reset in the middle of DRAIN
    set_basic();
    fork send_x(); send_f(); join
    cyc = 0;
    while (!m_valid_y && cyc < 100) begin @(negedge clk); cyc++; end
    check("drain_reached", m_valid_y, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_drain");
    @(negedge clk);
    reset_n = 1'b1;
    set_basic(); do_run(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
